vector_popcount_seq: RTL and testbench
======================================

// Module: vector_popcount_seq
// PURPOSE
//   Multi-cycle population counter for wide vectors. Accepts one VWIDTH-bit vector via valid/ready.
//   Counts it CWIDTH bits per cycle through one registered chunk adder stage into an accumulator.
//   Returns the total via valid/ready. Trades latency for area vs. a full-width adder tree.
//   Sits between a requester (status/mask scanners) and consumers of the bit count.
// PARAMETERS
//   VWIDTH      64                    Input vector width; must be a multiple of CWIDTH
//   CWIDTH      8                     Bits counted per cycle (chunk width), >= 1
//   SEARCH_VAL  1'b1                  1: count 1's, 0: count 0's
//   SWIDTH      $clog2(VWIDTH+1)      Sum width, treat as localparam; holds full count VWIDTH
// PORTS
//   clk        in   1        Clock, all logic on posedge
//   rst_n      in   1        Asynchronous reset, active low
//   abort      in   1        Synchronous cancel of in-flight operation
//   in_valid   in   1        Input vector valid
//   in_ready   out  1        Block can accept a vector (IDLE and !abort)
//   in_vector  in   VWIDTH   Vector to count; sampled only on accept
//   out_valid  out  1        out_sum valid; held until out_ready
//   out_ready  in   1        Consumer accepts result
//   out_sum    out  SWIDTH   Number of SEARCH_VAL bits in accepted vector
//   busy       out  1        High in any state other than IDLE
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, out_valid=0, out_sum=0, busy=0, accumulator=0,
//     chunk pipe valid=0, chunk index=0. in_ready=1 on the first cycle after release.
//   NCHUNK=VWIDTH/CWIDTH; chunk count width $clog2(CWIDTH+1); accumulator width SWIDTH, never wraps.
//   States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//   IDLE: in_ready=1 unless abort. Accept = in_valid & in_ready.
//     On accept, latch in_vector into shift reg, clear accumulator and index, go to RUN.
//   RUN: each cycle, count SEARCH_VAL bits of shift reg [CWIDTH-1:0] into chunk reg (pipe valid=1).
//     Shift reg shifts right by CWIDTH; vacated bits fill with ~SEARCH_VAL; index++.
//     After issuing chunk NCHUNK-1, go to DRAIN.
//   Accumulator adds chunk reg every cycle its pipe valid is set, in RUN and DRAIN.
//   DRAIN: no new chunk issued, pipe valid clears; final chunk added; go to DONE.
//   DONE: out_valid=1, out_sum=accumulator, both stable until out_ready=1.
//     On out_valid & out_ready, go to IDLE next cycle; out_valid=0 in IDLE.
//   Latency: accept at cycle T; out_valid first high at T+NCHUNK+2.
//   Minimum spacing between accepts is NCHUNK+3 cycles, with out_ready tied high.
//   No accept in DONE, even when out_ready=1 (in_ready=0 outside IDLE).
//   abort=1 in RUN/DRAIN/DONE: go to IDLE next cycle; pipe valid, accumulator, out_valid cleared.
//     The aborted result is never presented.
//   abort=1 in IDLE: in_ready=0, so in_valid is not accepted.
//   abort and out_ready both high in DONE: abort wins; the result counts as dropped.
//   Reset mid-operation: immediate return to reset values; no partial result ever emitted.
//   NCHUNK=1: RUN lasts one cycle; latency is 3.
// CONFIGURATION
//   VECTOR_POPCOUNT_SEQ_EARLY_EXIT_EN
//   Defined: in RUN, after issuing a chunk, if the shifted shift reg equals the all-~SEARCH_VAL fill,
//     go to DRAIN immediately; remaining chunks are skipped.
//     Latency is T+k+2, where k = number of chunks issued (min 1).
//   Undefined: comparator absent; latency is always T+NCHUNK+2.
//   Result values are identical with and without the macro.
// TESTING (VWIDTH=64, CWIDTH=8 unless noted)
//   1. SEARCH_VAL=1, vector 64'hFFFF_FFFF_FFFF_FFFF, out_ready=1
//      -> out_sum=7'd64 (no overflow), out_valid at T+10 for 1 cycle.
//   2. SEARCH_VAL=1, vector 64'h0000_0000_0000_0001
//      -> out_sum=1 at T+10; with EARLY_EXIT_EN, out_sum=1 at T+3.
//   3. Vector 64'h0F0F_0F0F_0F0F_0F0F, out_ready=0 for 5 cycles after out_valid
//      -> out_sum=32 held stable, in_ready=0; one cycle after out_ready=1, out_valid=0 and in_ready=1.
//   4. abort pulse at T+4 during RUN -> IDLE at T+5, out_valid never asserted;
//      next vector 64'h00FF_00FF_00FF_00FF -> out_sum=32.
//   5. SEARCH_VAL=0, vector 64'h0000_0000_0000_00FF -> out_sum=56 at T+10.
//      With EARLY_EXIT_EN: still 56, at T+10, since the high chunks contain zeros.
//   6. rst_n low at T+3 mid-RUN -> out_valid=0, out_sum=0, busy=0 asynchronously;
//      after release in_ready=1 and vector 64'h8000_0000_0000_0000 -> out_sum=1.

Source files
------------

// File: rtl/vector_popcount_seq_if.sv
// Request/result handshake bundle for vector_popcount_seq.
// master = requester side, slave = counter side.
interface vector_popcount_seq_if #(
   parameter int unsigned VWIDTH = 64,
   parameter int unsigned SWIDTH = $clog2(VWIDTH + 1)
) ();
   logic              abort;
   logic              in_valid;
   logic              in_ready;
   logic [VWIDTH-1:0] in_vector;
   logic              out_valid;
   logic              out_ready;
   logic [SWIDTH-1:0] out_sum;
   logic              busy;

   modport master (
      output abort, in_valid, in_vector, out_ready,
      input  in_ready, out_valid, out_sum, busy
   );

   modport slave (
      input  abort, in_valid, in_vector, out_ready,
      output in_ready, out_valid, out_sum, busy
   );
endinterface

// File: rtl/vector_popcount_seq.sv
// Sequential population counter: CWIDTH bits per cycle through a registered chunk stage.
// Optional macro VECTOR_POPCOUNT_SEQ_EARLY_EXIT_EN skips chunks once the remainder is all fill.
module vector_popcount_seq #(
   parameter int unsigned VWIDTH     = 64,
   parameter int unsigned CWIDTH     = 8,
   parameter bit          SEARCH_VAL = 1'b1
) (
   input logic                  clk,
   input logic                  rst_n,
   vector_popcount_seq_if.slave bus_io
);
   localparam int unsigned SWIDTH = $clog2(VWIDTH + 1);
   localparam int unsigned NCHUNK = VWIDTH / CWIDTH;
   localparam int unsigned CNTW   = $clog2(CWIDTH + 1);
   localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(NCHUNK - 1);
   localparam logic [VWIDTH-1:0] FILL     = {VWIDTH{~SEARCH_VAL}};

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e            state_q;
   logic [VWIDTH-1:0] shift_q;
   logic [IDXW-1:0]   idx_q;
   logic [CNTW-1:0]   chunk_q;
   logic              pipe_v_q;
   logic [SWIDTH-1:0] acc_q;
   logic              out_valid_q;

   logic              in_ready;
   logic              early_exit;
   logic [CNTW-1:0]   chunk_cnt;
   logic [VWIDTH-1:0] shift_nxt;

   always_comb begin
      chunk_cnt = '0;
      for (int i = 0; i < int'(CWIDTH); i++) begin
         if (shift_q[i] == SEARCH_VAL) chunk_cnt = chunk_cnt + 1'b1;
      end
   end

   // Vacated bits take the non-searched value so they never count.
   if (NCHUNK > 1) begin : g_shift
      assign shift_nxt = {{CWIDTH{~SEARCH_VAL}}, shift_q[VWIDTH-1:CWIDTH]};
   end else begin : g_noshift
      assign shift_nxt = FILL;
   end

`ifdef VECTOR_POPCOUNT_SEQ_EARLY_EXIT_EN
   assign early_exit = (shift_nxt == FILL);
`else
   assign early_exit = 1'b0;
`endif

   assign in_ready = (state_q == StIdle) && !bus_io.abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         shift_q     <= '0;
         idx_q       <= '0;
         chunk_q     <= '0;
         pipe_v_q    <= 1'b0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
      end else if (bus_io.abort && (state_q != StIdle)) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         pipe_v_q    <= 1'b0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus_io.in_valid && in_ready) begin
                  shift_q <= bus_io.in_vector;
                  acc_q   <= '0;
                  idx_q   <= '0;
                  state_q <= StRun;
               end
            end
            StRun: begin
               chunk_q  <= chunk_cnt;
               pipe_v_q <= 1'b1;
               shift_q  <= shift_nxt;
               idx_q    <= idx_q + 1'b1;
               if (pipe_v_q) acc_q <= acc_q + SWIDTH'(chunk_q);
               if ((idx_q == LAST_IDX) || early_exit) state_q <= StDrain;
            end
            StDrain: begin
               pipe_v_q    <= 1'b0;
               if (pipe_v_q) acc_q <= acc_q + SWIDTH'(chunk_q);
               out_valid_q <= 1'b1;
               state_q     <= StDone;
            end
            StDone: begin
               if (bus_io.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.in_ready  = in_ready;
   assign bus_io.out_valid = out_valid_q;
   assign bus_io.out_sum   = acc_q;
   assign bus_io.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_vector_popcount_seq.sv
// Scoreboard bench for vector_popcount_seq: three instances (count 1s, count 0s, single chunk).
// A monitor pops expected {instance, sum, due cycle} entries whenever an out_valid rises.
module tb_vector_popcount_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int unsigned cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [2:0]  in_valid  = '0;
   logic [2:0]  abort     = '0;
   logic [2:0]  out_ready = '1;
   logic [63:0] vec       = '0;
   logic [2:0]  in_ready, out_valid, busy;
   logic [6:0]  osum [3];

   vector_popcount_seq_if #(.VWIDTH(64)) if0 ();
   vector_popcount_seq_if #(.VWIDTH(64)) if1 ();
   vector_popcount_seq_if #(.VWIDTH(8))  if2 ();

   vector_popcount_seq #(.VWIDTH(64), .CWIDTH(8), .SEARCH_VAL(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus_io(if0));
   vector_popcount_seq #(.VWIDTH(64), .CWIDTH(8), .SEARCH_VAL(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus_io(if1));
   vector_popcount_seq #(.VWIDTH(8), .CWIDTH(8), .SEARCH_VAL(1'b1)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus_io(if2));

   assign if0.abort = abort[0];  assign if0.in_valid = in_valid[0];
   assign if0.out_ready = out_ready[0];  assign if0.in_vector = vec;
   assign if1.abort = abort[1];  assign if1.in_valid = in_valid[1];
   assign if1.out_ready = out_ready[1];  assign if1.in_vector = vec;
   assign if2.abort = abort[2];  assign if2.in_valid = in_valid[2];
   assign if2.out_ready = out_ready[2];  assign if2.in_vector = vec[7:0];

   assign in_ready  = {if2.in_ready, if1.in_ready, if0.in_ready};
   assign out_valid = {if2.out_valid, if1.out_valid, if0.out_valid};
   assign busy      = {if2.busy, if1.busy, if0.busy};
   assign osum[0]   = if0.out_sum;
   assign osum[1]   = if1.out_sum;
   assign osum[2]   = {3'b000, if2.out_sum};

   typedef struct {
      int          d;
      logic [6:0]  sum;
      int unsigned due;
   } exp_t;
   exp_t q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Cycles from accept to first out_valid: chunks issued plus two.
   function automatic int unsigned exp_lat(input int d, input logic [63:0] v);
      int unsigned nc = (d == 2) ? 1 : 8;
      int unsigned k  = nc;
`ifdef VECTOR_POPCOUNT_SEQ_EARLY_EXIT_EN
      logic sv = (d != 1);
      k = 1;
      for (int c = 0; c < int'(nc); c++)
         for (int b = 0; b < 8; b++)
            if (v[c*8+b] == sv) k = c + 1;
`endif
      return k + 2;
   endfunction

   // Monitor: runs #1 after every rising edge.
   initial begin
      bit   seen [3];
      exp_t e;
      for (int i = 0; i < 3; i++) seen[i] = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 3; i++) begin
            if (out_valid[i] && !seen[i]) begin
               seen[i] = 1'b1;
               if (q.size() == 0) begin
                  check("unexpected_result", 64'(i), 64'hFFFF);
               end else begin
                  e = q.pop_front();
                  check("result_instance", 64'(i), 64'(e.d));
                  check("result_sum", 64'(osum[i]), 64'(e.sum));
                  check("result_latency", 64'(cyc), 64'(e.due));
               end
            end
            if (!out_valid[i]) seen[i] = 1'b0;
         end
      end
   end

   // Called #1 after an edge; returns #1 after the edge one cycle past the accept.
   task automatic send(input int d, input logic [63:0] v, input logic [6:0] s, input bit push);
      exp_t e;
      int   n = 0;
      vec = v;
      in_valid[d] = 1'b1;
      #1;
      while (!in_ready[d] && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("accept_ready", 64'(in_ready[d]), 64'd1);
      if (push) begin
         e.d = d;
         e.sum = s;
         e.due = cyc + exp_lat(d, v);
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid[d] = 1'b0;
   endtask

   task automatic wait_done(input int d);
      int n = 0;
      while (!out_valid[d] && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("done_timeout", 64'(out_valid[d]), 64'd1);
      @(posedge clk);
      #1;
      check("valid_one_cycle", 64'(out_valid[d]), 64'd0);
      check("ready_after_done", 64'(in_ready[d]), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 64'(out_valid[0]), 64'd0);
      check("reset_sum", 64'(osum[0]), 64'd0);
      check("reset_busy", 64'(busy[0]), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_in_ready", 64'(in_ready), 64'd7);

      // Full-count vector, no overflow
      send(0, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 1'b1);
      wait_done(0);

      // Single low bit; early exit shortens latency when enabled
      send(0, 64'h0000_0000_0000_0001, 7'd1, 1'b1);
      wait_done(0);

      // Backpressure: result held for five cycles
      out_ready[0] = 1'b0;
      send(0, 64'h0F0F_0F0F_0F0F_0F0F, 7'd32, 1'b1);
      begin
         int n = 0;
         while (!out_valid[0] && n < 40) begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", 64'(out_valid[0]), 64'd1);
         check("hold_sum", 64'(osum[0]), 64'd32);
         check("hold_in_ready", 64'(in_ready[0]), 64'd0);
         @(posedge clk);
         #1;
      end
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      check("release_valid", 64'(out_valid[0]), 64'd0);
      check("release_in_ready", 64'(in_ready[0]), 64'd1);

      // Abort at T+4, then a fresh vector
      send(0, 64'hFFFF_0000_0000_0000, 7'd16, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      abort[0] = 1'b1;
      check("abort_busy_before", 64'(busy[0]), 64'd1);
      @(posedge clk);
      #1;
      abort[0] = 1'b0;
      check("abort_idle", 64'(busy[0]), 64'd0);
      check("abort_no_valid", 64'(out_valid[0]), 64'd0);
      send(0, 64'h00FF_00FF_00FF_00FF, 7'd32, 1'b1);
      wait_done(0);

      // Abort while idle blocks acceptance
      abort[0] = 1'b1;
      in_valid[0] = 1'b1;
      vec = 64'hDEAD_BEEF_0000_0001;
      #1;
      check("idle_abort_ready", 64'(in_ready[0]), 64'd0);
      @(posedge clk);
      #1;
      check("idle_abort_busy", 64'(busy[0]), 64'd0);
      in_valid[0] = 1'b0;
      abort[0] = 1'b0;

      // Counting zeros
      send(1, 64'h0000_0000_0000_00FF, 7'd56, 1'b1);
      wait_done(1);

      // Async reset mid-RUN discards the partial count
      send(0, 64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("partial_acc", 64'(osum[0]), 64'd8);
      rst_n = 1'b0;
      #1;
      check("async_out_valid", 64'(out_valid[0]), 64'd0);
      check("async_sum", 64'(osum[0]), 64'd0);
      check("async_busy", 64'(busy[0]), 64'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_ready", 64'(in_ready[0]), 64'd1);
      send(0, 64'h8000_0000_0000_0000, 7'd1, 1'b1);
      wait_done(0);

      // Single-chunk instance: latency 3
      send(2, 64'h0000_0000_0000_00A5, 7'd4, 1'b1);
      wait_done(2);

      repeat (5) @(posedge clk);
      #1;
      check("queue_drained", 64'(q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
